// File: rtl/gerenciador_servos_pkg.sv
// Shared move codes, FSM state encoding and decode helper for the servo manager.
package gerenciador_servos_pkg;

  localparam logic [2:0] MOVE_BASE0    = 3'b000;
  localparam logic [2:0] MOVE_BASE1    = 3'b001;
  localparam logic [2:0] MOVE_BASE2    = 3'b010;
  localparam logic [2:0] MOVE_BASE3    = 3'b011;
  localparam logic [2:0] MOVE_TAMPA    = 3'b100;
  localparam logic [2:0] MOVE_PETELECO = 3'b101;

  // State codes double as the db_estado debug value.
  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    ESPERA       = 4'd1,
    DECODIFICA   = 4'd2,
    PREP_BASE    = 4'd3,
    ESPERA_BASE  = 4'd4,
    PREP_TAMPA   = 4'd5,
    ESPERA_TAMPA = 4'd6,
    PREP_IDA     = 4'd7,
    ESPERA_IDA   = 4'd8,
    PREP_VOLTA   = 4'd9,
    ESPERA_VOLTA = 4'd10,
    FINAL        = 4'd11,
    ERRO         = 4'd12
  } estado_t;

  // True when exactly one servo claims the move.
  function automatic logic decode_valido(input logic [2:0] flags);
    return $onehot(flags);
  endfunction

endpackage

// File: rtl/gerenciador_servos_uc.sv
// Servo manager control unit: Moore FSM sequencing zero/count/wait per servo.
module gerenciador_servos_uc
  import gerenciador_servos_pkg::*;
#(
  parameter bit PETELECO_RETORNA = 1'b1,
  parameter int DB_W             = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iniciar,
  input  logic [2:0]      move_in,
  output logic [2:0]      move,
  input  logic            move_servo_peteleco,
  input  logic            move_servo_tampa,
  input  logic            move_servo_base,
  input  logic            fim_servo_peteleco,
  input  logic            fim_servo_tampa,
  input  logic            fim_servo_base,
  output logic            zera_servo_peteleco,
  output logic            zera_servo_tampa,
  output logic            zera_servo_base,
  output logic            conta_servo_peteleco,
  output logic            conta_servo_tampa,
  output logic            conta_servo_base,
  output logic            gira,
  output logic            shifta_servo_tampa,
  output logic            we_registrador,
  output logic            ocupado,
  output logic            pronto,
  output logic            erro,
  output logic [DB_W-1:0] db_estado
);

  estado_t    state_q, state_d;
  logic [2:0] zera_q, zera_d;   // {peteleco, tampa, base}
  logic [2:0] conta_q, conta_d; // {peteleco, tampa, base}
  logic       we_q, we_d;
  logic       shifta_q, shifta_d;
  logic       ocupado_q, ocupado_d;
  logic       pronto_q, pronto_d;
  logic       gira_q, gira_d;
  logic       erro_q, erro_d;
  logic [2:0] move_q, move_d;

  // Next-state selection from the current state and datapath flags.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INICIAL:    state_d = ESPERA;
      ESPERA:     if (iniciar) state_d = DECODIFICA;
      DECODIFICA: begin
        if (!decode_valido({move_servo_peteleco, move_servo_tampa, move_servo_base}))
          state_d = ERRO;
        else if (move_servo_base)  state_d = PREP_BASE;
        else if (move_servo_tampa) state_d = PREP_TAMPA;
        else                       state_d = PREP_IDA;
      end
      PREP_BASE:    state_d = ESPERA_BASE;
      ESPERA_BASE:  if (fim_servo_base) state_d = FINAL;
      PREP_TAMPA:   state_d = ESPERA_TAMPA;
      ESPERA_TAMPA: if (fim_servo_tampa) state_d = FINAL;
      PREP_IDA:     state_d = ESPERA_IDA;
      ESPERA_IDA:   if (fim_servo_peteleco) state_d = PETELECO_RETORNA ? PREP_VOLTA : FINAL;
      PREP_VOLTA:   state_d = ESPERA_VOLTA;
      ESPERA_VOLTA: if (fim_servo_peteleco) state_d = FINAL;
      FINAL:        state_d = ESPERA;
      ERRO:         state_d = ESPERA;
      default:      state_d = INICIAL;
    endcase
  end

  // Output decode of the upcoming state so registered outputs line up with state_q.
  always_comb begin
    zera_d    = '0;
    conta_d   = '0;
    we_d      = 1'b0;
    shifta_d  = 1'b0;
    pronto_d  = 1'b0;
    ocupado_d = 1'b0;
    gira_d    = gira_q;
    erro_d    = erro_q;
    move_d    = move_q;
    if (state_q == ESPERA && iniciar) begin
      move_d = move_in;
      erro_d = 1'b0;
    end
    unique case (state_d)
      INICIAL:      zera_d = '1;
      DECODIFICA:   ocupado_d = 1'b1;
      PREP_BASE:    begin ocupado_d = 1'b1; we_d = 1'b1; zera_d = 3'b001; end
      ESPERA_BASE:  begin ocupado_d = 1'b1; conta_d = 3'b001; end
      PREP_TAMPA:   begin ocupado_d = 1'b1; shifta_d = 1'b1; zera_d = 3'b010; end
      ESPERA_TAMPA: begin ocupado_d = 1'b1; conta_d = 3'b010; end
      PREP_IDA:     begin ocupado_d = 1'b1; gira_d = 1'b1; zera_d = 3'b100; end
      ESPERA_IDA:   begin ocupado_d = 1'b1; conta_d = 3'b100; end
      PREP_VOLTA:   begin ocupado_d = 1'b1; gira_d = 1'b0; zera_d = 3'b100; end
      ESPERA_VOLTA: begin ocupado_d = 1'b1; conta_d = 3'b100; end
      FINAL:        pronto_d = 1'b1;
      ERRO:         begin pronto_d = 1'b1; erro_d = 1'b1; end
      default:      ;
    endcase
  end

  // State and registered Moore outputs; reset forces INICIAL from anywhere.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= INICIAL;
      zera_q    <= '1;
      conta_q   <= '0;
      we_q      <= 1'b0;
      shifta_q  <= 1'b0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
      gira_q    <= 1'b0;
      erro_q    <= 1'b0;
      move_q    <= '0;
    end else begin
      state_q   <= state_d;
      zera_q    <= zera_d;
      conta_q   <= conta_d;
      we_q      <= we_d;
      shifta_q  <= shifta_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
      gira_q    <= gira_d;
      erro_q    <= erro_d;
      move_q    <= move_d;
    end
  end

  assign move                 = move_q;
  assign zera_servo_peteleco  = zera_q[2];
  assign zera_servo_tampa     = zera_q[1];
  assign zera_servo_base      = zera_q[0];
  assign conta_servo_peteleco = conta_q[2];
  assign conta_servo_tampa    = conta_q[1];
  assign conta_servo_base     = conta_q[0];
  assign we_registrador       = we_q;
  assign shifta_servo_tampa   = shifta_q;
  assign pronto               = pronto_q;
  assign ocupado              = ocupado_q;
  assign gira                 = gira_q;
  assign erro                 = erro_q;
  assign db_estado            = DB_W'(state_q);

endmodule

// File: doc/gerenciador_servos_uc.md
Name: gerenciador_servos_uc

Overview:
Control unit (Moore FSM) that sequences the servo manager datapath: timing counters, lid T flip-flop, base position register and flip (peteleco) position.
Accepts one cube move per iniciar/pronto handshake, latches it and drives the datapath move bus.
Runs the per-servo zero/count/wait-for-fim sequence for that move and reports completion or error.
Sits between the solver sequencer (move source) and gerenciador_servos_fd.

Parameters:
PETELECO_RETORNA, 1, 1 = flip move does out-stroke then return-stroke; 0 = out-stroke only (gira left at 1 until next flip or reset)
DB_W, 4, width of db_estado

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
iniciar  in  1  request: start move on move_in; sampled only in ESPERA
move_in  in  3  requested move code
move  out  3  latched move driven to datapath (matcher and base register)
move_servo_peteleco / move_servo_tampa / move_servo_base  in  1 each  datapath decode of move
fim_servo_peteleco / fim_servo_tampa / fim_servo_base  in  1 each  settle-time counter terminal flags
zera_servo_peteleco / zera_servo_tampa / zera_servo_base  out  1 each  counter clears
conta_servo_peteleco / conta_servo_tampa / conta_servo_base  out  1 each  counter enables
gira  out  1  flip servo position; registered, held between states
shifta_servo_tampa  out  1  one-cycle toggle of lid flip-flop
we_registrador  out  1  one-cycle write of base position register
ocupado  out  1  high from accept to pronto
pronto  out  1  one-cycle done pulse
erro  out  1  sticky invalid-move flag, cleared on next accepted iniciar
db_estado  out  DB_W  state code

Behaviour:
- Move codes (package): 000-011 base position 0-3; 100 lid toggle; 101 flip; 110/111 invalid. No servo flag high from the datapath decode.
- Reset (reset=0 at clock edge):
  - Enters INICIAL from any state, including mid-move.
  - move=000, gira=0, erro=0.
  - INICIAL asserts all three zera_* for one cycle, then ESPERA.
- ESPERA:
  - Outputs idle.
  - iniciar=1 latches move_in into move, clears erro, goes to DECODIFICA.
  - iniciar outside ESPERA is ignored.
- DECODIFICA (one cycle, decode settles on latched move):
  - Exactly one move_servo_* high: route to that servo's PREP state.
  - Zero or more than one high: ERRO.
- Base path:
  - PREP_BASE (1 cycle): we_registrador=1, zera_servo_base=1.
  - ESPERA_BASE: conta_servo_base=1 until fim_servo_base=1, then FINAL.
- Lid path:
  - PREP_TAMPA (1 cycle): shifta_servo_tampa=1, zera_servo_tampa=1.
  - ESPERA_TAMPA: conta until fim_servo_tampa=1, then FINAL.
- Flip path:
  - PREP_IDA (1 cycle): gira<=1, zera_servo_peteleco=1.
  - ESPERA_IDA: conta until fim_servo_peteleco=1.
  - If PETELECO_RETORNA: PREP_VOLTA (gira<=0, zera) then ESPERA_VOLTA (conta until fim), then FINAL.
  - Otherwise ESPERA_IDA goes straight to FINAL.
- fim handling:
  - fim is sampled only in the matching ESPERA_* state.
  - A fim already high on entry to a wait state is stale, because the PREP zera cleared it; the wait state requires conta active.
  - Other servos' fim inputs are ignored.
- FINAL (1 cycle): pronto=1, ocupado=0, then ESPERA. iniciar in this cycle is ignored.
- ERRO (1 cycle): erro<=1, pronto=1, then ESPERA.
- ocupado=1 in every state from DECODIFICA through the last wait state.
- Latency from accept: 1 (DECODIFICA) + 1 (PREP) + settle count + 1 fim-detect + 1 FINAL.

Decomposition:
- Package gerenciador_servos_pkg holds:
  - move codes: MOVE_BASE0..3, MOVE_TAMPA, MOVE_PETELECO
  - state encodings and db_estado codes: INICIAL=0, ESPERA=1, DECODIFICA=2, PREP_BASE=3, ESPERA_BASE=4, PREP_TAMPA=5, ESPERA_TAMPA=6, PREP_IDA=7, ESPERA_IDA=8, PREP_VOLTA=9, ESPERA_VOLTA=10, FINAL=11, ERRO=12
- Single module: state register, next-state logic, and Moore output decode.
- gira and move are registered.
- No sub-module.

Test Plan:
- Bench models the decode from the move codes and drives fim_* directly.
- reset=0 mid ESPERA_IDA with gira=1 -> next cycle INICIAL, zera_*=111, gira=0, move=000; then ESPERA, ocupado=0.
- iniciar with move_in=010 -> DECODIFICA, then PREP_BASE with we_registrador=1 and move=010; fim_servo_base pulsed 5 cycles later -> pronto exactly 1 cycle after fim detect; erro=0.
- move_in=100 -> exactly one shifta_servo_tampa pulse; conta_servo_tampa high until fim_servo_tampa; fim_servo_base pulses during the wait have no effect.
- move_in=101 with PETELECO_RETORNA=1 -> gira 0→1 in PREP_IDA, then 1→0 after the first fim; two zera pulses; pronto only after the second fim.
- move_in=111 -> ERRO, pronto=1, erro stays 1; next iniciar with 000 clears erro and the base sequence completes.
- iniciar held high through a whole move -> only one accept per ESPERA visit; move_in changes while busy do not alter move.
